// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the programmable CNN layer sequencer.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] ENG_CONV = 3'd0;
    localparam logic [2:0] ENG_RELU = 3'd1;
    localparam logic [2:0] ENG_POOL = 3'd2;
    localparam logic [2:0] ENG_FC   = 3'd3;

    localparam int LENET_LEN = 7;
    localparam logic [2:0] LENET_PROG [LENET_LEN] = '{
        ENG_CONV, ENG_RELU, ENG_POOL, ENG_CONV, ENG_RELU, ENG_POOL, ENG_FC
    };

    function automatic logic [7:0] eng_onehot(input logic [2:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/layer_seq_if.sv
// Engine-side bus and the single DRAM port of the layer sequencer.
interface layer_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 4
);
    logic [NUM_ENG-1:0]            eng_en;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
    logic [NUM_ENG-1:0]            eng_wr;
    logic [NUM_ENG-1:0]            eng_rd;
    logic [DATA_WIDTH-1:0]         data_out;
    logic [ADDR_WIDTH-1:0]         addr_in;
    logic [ADDR_WIDTH-1:0]         addr_out;
    logic                          dram_en_wr;
    logic                          dram_en_rd;

    modport master (
        output eng_en, data_out, addr_in, addr_out, dram_en_wr, dram_en_rd,
        input  eng_done, eng_data_out, eng_addr_in, eng_addr_out, eng_wr, eng_rd
    );

    modport slave (
        input  eng_en, data_out, addr_in, addr_out, dram_en_wr, dram_en_rd,
        output eng_done, eng_data_out, eng_addr_in, eng_addr_out, eng_wr, eng_rd
    );
endinterface

// File: rtl/layer_seq_bus_mux.sv
// NUM_ENG-to-1 DRAM bus selector; drives all zeros when not valid or the id is out of range.
module seq_bus_mux
    import layer_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 4
) (
    input  logic [2:0]                    sel,
    input  logic                          valid,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
    input  logic [NUM_ENG-1:0]            eng_wr,
    input  logic [NUM_ENG-1:0]            eng_rd,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [ADDR_WIDTH-1:0]         addr_in,
    output logic [ADDR_WIDTH-1:0]         addr_out,
    output logic                          dram_en_wr,
    output logic                          dram_en_rd
);
    logic [NUM_ENG-1:0] hit_s;

    // Ids at or above NUM_ENG shift out of the truncated one-hot, leaving no hit.
    always_comb begin
        if (valid) begin
            hit_s = NUM_ENG'(eng_onehot(sel));
        end else begin
            hit_s = '0;
        end
    end

    // AND-OR select of the hit engine's bus.
    always_comb begin
        data_out   = '0;
        addr_in    = '0;
        addr_out   = '0;
        dram_en_wr = 1'b0;
        dram_en_rd = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            data_out   = data_out | (eng_data_out[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit_s[k]}});
            addr_in    = addr_in  | (eng_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH]  & {ADDR_WIDTH{hit_s[k]}});
            addr_out   = addr_out | (eng_addr_out[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{hit_s[k]}});
            dram_en_wr = dram_en_wr | (eng_wr[k] & hit_s[k]);
            dram_en_rd = dram_en_rd | (eng_rd[k] & hit_s[k]);
        end
    end
endmodule

// File: rtl/layer_seq.sv
// Programmable layer sequencer: steps a loaded stage program across the compute engines,
// with abort, per-stage watchdog and spurious-done detection.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_ENG    = 4,
    parameter int MAX_STAGES = 16,
    parameter int TMO_WIDTH  = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          abort,
    input  logic                          rdy_data,
    input  logic                          cfg_we,
    input  logic [$clog2(MAX_STAGES)-1:0] cfg_addr,
    input  logic [2:0]                    cfg_eng,
    input  logic [$clog2(MAX_STAGES):0]   cfg_len,
    layer_seq_if.master                   bus,
    output logic [$clog2(MAX_STAGES)-1:0] stage_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          done_one_layer,
    output logic                          err
);
    localparam int SW = $clog2(MAX_STAGES);
    localparam logic [SW:0]          MAX_LEN    = (SW+1)'(MAX_STAGES);
    localparam logic [SW-1:0]        STAGE_LAST = {SW{1'b1}};
    localparam logic [TMO_WIDTH-1:0] TMO_LAST   = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

    state_t                 state_r, state_nx_s;
    logic [SW-1:0]          stage_idx_r, stage_nx_s;
    logic [TMO_WIDTH-1:0]   tmo_cnt_r, tmo_nx_s;
    logic [SW:0]            len_q_r, len_nx_s;
    logic                   rdy_ff_r, en_prev_r, done_one_layer_r, dol_nx_s;
    logic [2:0]             tbl_r [MAX_STAGES];
    logic [2:0]             cur_eng_s;
    logic [NUM_ENG-1:0]     cur_hot_s;
    logic                   eng_valid_s, spur_s, acc_s, run_s;

    assign cur_eng_s   = tbl_r[stage_idx_r];
    assign cur_hot_s   = NUM_ENG'(eng_onehot(cur_eng_s));
    assign eng_valid_s = |cur_hot_s;
    assign spur_s      = |(bus.eng_done & ~cur_hot_s);
    assign acc_s       = |(bus.eng_done & cur_hot_s);
    assign run_s       = (state_r == ST_RUN);

    // Program table is deliberately left unreset; only IDLE writes land.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_r == ST_IDLE)) begin
            tbl_r[cfg_addr] <= cfg_eng;
        end
    end

    // Next-state logic; abort overrides everything, spurious done beats accepted done.
    always_comb begin
        state_nx_s = state_r;
        stage_nx_s = stage_idx_r;
        tmo_nx_s   = tmo_cnt_r;
        len_nx_s   = len_q_r;
        dol_nx_s   = 1'b0;
        if (abort) begin
            state_nx_s = ST_IDLE;
            stage_nx_s = '0;
            tmo_nx_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        len_nx_s   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
                        stage_nx_s = '0;
                        tmo_nx_s   = '0;
                        state_nx_s = (cfg_len == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!eng_valid_s || spur_s) begin
                        state_nx_s = ST_ERR;
                    end else if (acc_s) begin
                        stage_nx_s = (stage_idx_r == STAGE_LAST) ? stage_idx_r : stage_idx_r + 1'b1;
                        tmo_nx_s   = '0;
                        dol_nx_s   = 1'b1;
                        state_nx_s = ({1'b0, stage_idx_r} == len_q_r - 1'b1) ? ST_DONE : ST_RUN;
                    end else if (rdy_ff_r) begin
                        tmo_nx_s   = tmo_cnt_r + 1'b1;
                        state_nx_s = (tmo_cnt_r == TMO_LAST) ? ST_ERR : ST_RUN;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (enable && !en_prev_r) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                ST_ERR:  state_nx_s = ST_ERR;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, stage/watchdog counters and sampled handshake history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            stage_idx_r      <= '0;
            tmo_cnt_r        <= '0;
            len_q_r          <= '0;
            rdy_ff_r         <= 1'b0;
            en_prev_r        <= 1'b0;
            done_one_layer_r <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            stage_idx_r      <= stage_nx_s;
            tmo_cnt_r        <= tmo_nx_s;
            len_q_r          <= len_nx_s;
            rdy_ff_r         <= rdy_data;
            en_prev_r        <= enable;
            done_one_layer_r <= dol_nx_s;
        end
    end

    // Status decode and data-ready-gated engine enable.
    always_comb begin
        busy = run_s;
        done = (state_r == ST_DONE);
        err  = (state_r == ST_ERR);
        if (run_s && rdy_ff_r) begin
            bus.eng_en = cur_hot_s;
        end else begin
            bus.eng_en = '0;
        end
    end

    assign stage_idx      = stage_idx_r;
    assign done_one_layer = done_one_layer_r;

    seq_bus_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ENG    (NUM_ENG)
    ) u_mux (
        .sel          (cur_eng_s),
        .valid        (run_s),
        .eng_data_out (bus.eng_data_out),
        .eng_addr_in  (bus.eng_addr_in),
        .eng_addr_out (bus.eng_addr_out),
        .eng_wr       (bus.eng_wr),
        .eng_rd       (bus.eng_rd),
        .data_out     (bus.data_out),
        .addr_in      (bus.addr_in),
        .addr_out     (bus.addr_out),
        .dram_en_wr   (bus.dram_en_wr),
        .dram_en_rd   (bus.dram_en_rd)
    );
endmodule

// File: tb/tb_layer_seq.sv
// Directed-plus-random bench for layer_seq; a second instance with a short watchdog covers timeout.
module tb_layer_seq;
    import layer_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 18;
    localparam int NE = 4;
    localparam int MS = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst, enable, abort, rdy_data, cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [2:0]    cfg_eng;
    logic [SW:0]   cfg_len;
    logic [SW-1:0] stage_idx, stage_idx2;
    logic busy, done, dol, err, busy2, done2, dol2, err2;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ed [NE];
    logic [AW-1:0] ai [NE];
    logic [AW-1:0] ao [NE];
    logic          ew [NE];
    logic          er [NE];
    int            prog_m [MS];
    int            lat_m  [MS];

    layer_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE)) bus ();
    layer_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE)) bus2 ();

    layer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_STAGES(MS), .TMO_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort), .rdy_data(rdy_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_eng(cfg_eng), .cfg_len(cfg_len),
        .bus(bus), .stage_idx(stage_idx), .busy(busy), .done(done),
        .done_one_layer(dol), .err(err)
    );

    layer_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_STAGES(MS), .TMO_WIDTH(4)) dut_tmo (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort), .rdy_data(rdy_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_eng(cfg_eng), .cfg_len(cfg_len),
        .bus(bus2), .stage_idx(stage_idx2), .busy(busy2), .done(done2),
        .done_one_layer(dol2), .err(err2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int id);
        cfg_we   = 1'b1;
        cfg_addr = SW'(idx);
        cfg_eng  = 3'(id);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic chk_bus_zero(input string tag);
        chk({tag, "_eng_en"}, 64'(bus.eng_en), 64'(0));
        chk({tag, "_data_out"}, 64'(bus.data_out), 64'(0));
        chk({tag, "_addr_in"}, 64'(bus.addr_in), 64'(0));
        chk({tag, "_addr_out"}, 64'(bus.addr_out), 64'(0));
        chk({tag, "_wr"}, 64'(bus.dram_en_wr), 64'(0));
        chk({tag, "_rd"}, 64'(bus.dram_en_rd), 64'(0));
    endtask

    // Runs prog_m/lat_m for len stages; engines finish after lat_m enabled cycles.
    task automatic run_prog(input int len, input int drop_stage, input int drop_len,
                            input bit flicker, input int abort_stage);
        int stg = 0;
        int cnt = 0;
        int cyc = 0;
        int drop_left = 0;
        bit rdy_m, exp_dol, pulse, dropped;
        logic [NE-1:0] exp_en;
        exp_dol = 1'b0;
        dropped = 1'b0;
        cfg_len = (SW+1)'(len);
        enable  = 1'b1;
        step();
        enable  = 1'b0;
        rdy_m   = rdy_data;
        while (cyc < 4000) begin
            exp_en = (stg < len && rdy_m) ? (NE'(1) << prog_m[stg]) : '0;
            chk("eng_en", 64'(bus.eng_en), 64'(exp_en));
            chk("eng_en_onehot", 64'($countones(bus.eng_en) <= 1), 64'(1));
            chk("stage_idx", 64'(stage_idx), 64'(stg));
            chk("done_one_layer", 64'(dol), 64'(exp_dol));
            chk("done", 64'(done), 64'(stg == len));
            chk("busy", 64'(busy), 64'(stg < len));
            chk("data_out", 64'(bus.data_out), 64'((stg < len) ? ed[prog_m[stg]] : '0));
            chk("addr_in", 64'(bus.addr_in), 64'((stg < len) ? ai[prog_m[stg]] : '0));
            chk("addr_out", 64'(bus.addr_out), 64'((stg < len) ? ao[prog_m[stg]] : '0));
            chk("dram_en_wr", 64'(bus.dram_en_wr), 64'((stg < len) ? ew[prog_m[stg]] : 1'b0));
            chk("dram_en_rd", 64'(bus.dram_en_rd), 64'((stg < len) ? er[prog_m[stg]] : 1'b0));
            if (stg == len) break;
            bus.eng_done = '0;
            pulse = 1'b0;
            if (exp_en != '0) begin
                cnt++;
                if (cnt >= lat_m[stg]) pulse = 1'b1;
            end
            if (pulse) bus.eng_done[prog_m[stg]] = 1'b1;
            if (cyc == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = SW'(len - 1);
                cfg_eng  = 3'((prog_m[len-1] + 1) % NE);
            end else begin
                cfg_we = 1'b0;
            end
            if (flicker) begin
                rdy_data = ($urandom_range(3, 0) != 0);
            end else if (stg == drop_stage && !dropped && cnt == 5) begin
                rdy_data  = 1'b0;
                drop_left = drop_len;
                dropped   = 1'b1;
            end else if (drop_left > 0) begin
                drop_left--;
                if (drop_left == 0) rdy_data = 1'b1;
            end
            if (pulse && stg == abort_stage) abort = 1'b1;
            step();
            cyc++;
            bus.eng_done = '0;
            cfg_we = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort_dol", 64'(dol), 64'(0));
                chk("abort_stage_idx", 64'(stage_idx), 64'(0));
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_done", 64'(done), 64'(0));
                chk("abort_err", 64'(err), 64'(0));
                step();
                chk("abort_dol_later", 64'(dol), 64'(0));
                chk("abort_idle_busy", 64'(busy), 64'(0));
                return;
            end
            exp_dol = pulse;
            if (pulse) begin
                stg++;
                cnt = 0;
            end
            rdy_m = rdy_data;
        end
        chk("prog_finished", 64'(stg), 64'(len));
    endtask

    initial begin
        int n;
        int drop;
        int len;
        bit rdy_m, dropped;

        rst = 1'b1; enable = 1'b0; abort = 1'b0; rdy_data = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_eng = '0; cfg_len = '0;
        for (int k = 0; k < NE; k++) begin
            ed[k] = $urandom;
            ai[k] = AW'($urandom);
            ao[k] = AW'($urandom);
            ew[k] = 1'($urandom_range(1, 0));
            er[k] = ~ew[k];
            bus.eng_data_out[k*DW +: DW] = ed[k];
            bus.eng_addr_in[k*AW +: AW]  = ai[k];
            bus.eng_addr_out[k*AW +: AW] = ao[k];
            bus.eng_wr[k] = ew[k];
            bus.eng_rd[k] = er[k];
        end
        bus.eng_done = '0;
        bus2.eng_done = '0; bus2.eng_data_out = '0; bus2.eng_addr_in = '0;
        bus2.eng_addr_out = '0; bus2.eng_wr = '0; bus2.eng_rd = '0;

        // Reset state
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_dol", 64'(dol), 64'(0));
        chk("rst_stage_idx", 64'(stage_idx), 64'(0));
        chk_bus_zero("rst");
        rst = 1'b0;
        step();

        // LeNet program with a 100-cycle data-ready drop during stage 2
        for (int i = 0; i < LENET_LEN; i++) begin
            prog_m[i] = int'(LENET_PROG[i]);
            lat_m[i]  = 50;
            load(i, prog_m[i]);
        end
        rdy_data = 1'b1;
        step();
        run_prog(LENET_LEN, 2, 100, 1'b0, -1);
        step();
        chk("lenet_done_hold", 64'(done), 64'(1));
        chk("lenet_dol_single", 64'(dol), 64'(0));
        pulse_abort();
        chk("lenet_abort_done", 64'(done), 64'(0));

        // Spurious done from FC while CONV is active
        rdy_data = 1'b1;
        cfg_len = (SW+1)'(LENET_LEN);
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (3) step();
        chk("spur_pre_busy", 64'(busy), 64'(1));
        bus.eng_done = NE'(1) << int'(ENG_FC);
        step();
        bus.eng_done = '0;
        chk("spur_err", 64'(err), 64'(1));
        chk("spur_busy", 64'(busy), 64'(0));
        chk_bus_zero("spur");
        step();
        chk("spur_err_hold", 64'(err), 64'(1));
        pulse_abort();
        chk("spur_abort_err", 64'(err), 64'(0));
        chk("spur_abort_stage", 64'(stage_idx), 64'(0));
        chk("spur_abort_busy", 64'(busy), 64'(0));

        // Watchdog on the short-timeout instance, with a ready drop mid-count
        pulse_abort();
        rdy_data = 1'b1;
        step();
        enable = 1'b1;
        step();
        enable = 1'b0;
        n = 0; drop = 0; dropped = 1'b0; rdy_m = rdy_data;
        for (int c = 0; c < 300; c++) begin
            chk("tmo_err", 64'(err2), 64'(n >= 15));
            chk("tmo_busy", 64'(busy2), 64'(n < 15));
            if (n >= 15) break;
            if (n == 7 && !dropped) begin
                rdy_data = 1'b0; dropped = 1'b1; drop = 40;
            end else if (drop > 0) begin
                drop--;
                if (drop == 0) rdy_data = 1'b1;
            end
            step();
            n += int'(rdy_m);
            rdy_m = rdy_data;
        end
        chk("tmo_reached", 64'(n), 64'(15));
        rdy_data = 1'b1;
        pulse_abort();
        chk("tmo_abort_err", 64'(err2), 64'(0));

        // Abort coincident with the accepted done of stage 3
        for (int i = 0; i < LENET_LEN; i++) lat_m[i] = 10;
        step();
        run_prog(LENET_LEN, -1, 0, 1'b0, 3);

        // Asynchronous reset mid-RUN
        cfg_len = (SW+1)'(LENET_LEN);
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (4) step();
        chk("mid_rst_pre_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_stage", 64'(stage_idx), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk_bus_zero("mid_rst");
        step();
        rst = 1'b0;
        step();

        // Zero-length program, then re-arm from DONE
        cfg_len = '0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zero_eng_en", 64'(bus.eng_en), 64'(0));
            chk("zero_done_hold", 64'(done), 64'(1));
        end
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("rearm_done", 64'(done), 64'(0));
        chk("rearm_busy", 64'(busy), 64'(0));
        step();

        // Random programs with flickering data-ready
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(8, 1);
            for (int i = 0; i < len; i++) begin
                prog_m[i] = $urandom_range(NE - 1, 0);
                lat_m[i]  = $urandom_range(20, 1);
                load(i, prog_m[i]);
            end
            run_prog(len, -1, 0, 1'b1, -1);
            pulse_abort();
            rdy_data = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
